// File: rtl/booth_mult_arbiter_pkg.sv
// Shared types and constants for the Booth multiplier sequencer/arbiter.
package booth_mult_arbiter_pkg;
  localparam int DATA_W         = 16;
  localparam int PROD_W         = 32;
  localparam int MULT_LATENCY_C = 16;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic [PROD_W-1:0]        prod_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } arb_state_e;
endpackage

// File: rtl/booth_mult_arbiter_if.sv
// Request and response channels between requesters and the multiplier arbiter.
interface booth_mult_arbiter_if #(
  parameter int N_REQ = 2
);
  import booth_mult_arbiter_pkg::*;
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both 1; once raised, valid and its payload hold until that transfer.
  logic [N_REQ-1:0]  req_valid;
  logic [N_REQ-1:0]  req_ready;
  data_t [N_REQ-1:0] req_mc;
  data_t [N_REQ-1:0] req_mp;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  prod_t             rsp_prod;
  logic              rsp_err;

  modport master (
    output req_valid, req_mc, req_mp, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err
  );

  modport slave (
    input  req_valid, req_mc, req_mp, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err
  );
endinterface

// File: rtl/booth_mult_arbiter_rr_arbiter.sv
// Round-robin grant: scans upward from the pointer, pointer moves past each winner.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_valid,
  input  logic             advance,
  output logic [N_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_grant,
  output logic [ID_W-1:0]  ptr
);
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int off = 0; off < N_REQ; off++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
      idx = sum[ID_W-1:0];
      if (!any_grant && req_valid[idx]) begin
        any_grant     = 1'b1;
        grant_idx     = idx;
        grant_oh[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && any_grant)
      ptr_d = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one Booth multiplier between N_REQ requesters: grant, start, wait, respond.
module booth_mult_arbiter
  import booth_mult_arbiter_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int MULT_LATENCY = MULT_LATENCY_C,
  parameter int TIMEOUT_CYC  = 20,
  localparam int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  booth_mult_arbiter_if.slave bus,
  output logic              mult_start,
  output data_t             mult_mc,
  output data_t             mult_mp,
  input  logic              mult_ready,
  input  prod_t             mult_prod,
  output logic              busy,
  output arb_state_e        state_dbg,
  output logic [ID_W-1:0]   ptr_dbg
);
  // Counter is sized for whichever of timeout or multiplier latency is longer.
  localparam int CNT_LIM = (TIMEOUT_CYC > MULT_LATENCY) ? TIMEOUT_CYC : MULT_LATENCY;
  localparam int CNT_W   = $clog2(CNT_LIM + 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  data_t            mc_q, mc_d, mp_q, mp_d;
  logic [ID_W-1:0]  id_q, id_d;
  prod_t            prod_q, prod_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] grant_oh;
  logic [ID_W-1:0]  grant_idx;
  logic             any_grant;
  logic             grant_stb;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (bus.req_valid),
    .advance   (grant_stb),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_grant (any_grant),
    .ptr       (ptr_dbg)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mc_d      = mc_q;
    mp_d      = mp_q;
    id_d      = id_q;
    prod_d    = prod_q;
    err_d     = err_q;
    grant_stb = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_grant) begin
          grant_stb = 1'b1;
          mc_d      = bus.req_mc[grant_idx];
          mp_d      = bus.req_mp[grant_idx];
          id_d      = grant_idx;
          state_d   = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mult_ready) begin
          prod_d  = mult_prod;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mc_q    <= '0;
      mp_q    <= '0;
      id_q    <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      id_q    <= id_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE) ? grant_oh : '0;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_prod  = prod_q;
  assign bus.rsp_err   = err_q;
  assign mult_start    = (state_q == START);
  assign mult_mc       = mc_q;
  assign mult_mp       = mp_q;
  assign busy          = (state_q != IDLE);
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a fixed-latency multiplier stand-in.
module tb_booth_mult_arbiter;
  import booth_mult_arbiter_pkg::*;
  localparam int N_REQ = 2;
  localparam int ID_W  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_mult_arbiter_if #(.N_REQ(N_REQ)) bus();

  logic            mult_start, mult_ready, busy;
  data_t           mult_mc, mult_mp;
  prod_t           mult_prod;
  arb_state_e      state_dbg;
  logic [ID_W-1:0] ptr_dbg;

  booth_mult_arbiter #(.N_REQ(N_REQ), .MULT_LATENCY(16), .TIMEOUT_CYC(20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .mult_start (mult_start),
    .mult_mc    (mult_mc),
    .mult_mp    (mult_mp),
    .mult_ready (mult_ready),
    .mult_prod  (mult_prod),
    .busy       (busy),
    .state_dbg  (state_dbg),
    .ptr_dbg    (ptr_dbg)
  );

  // Multiplier stand-in: ready when its count reaches 16 after the start edge.
  logic  stub_run  = 1'b0;
  int    stub_cnt  = 0;
  prod_t stub_prod = '0;
  logic  stub_dead = 1'b0;
  always @(posedge clk) begin
    if (mult_start) begin
      stub_run  <= 1'b1;
      stub_cnt  <= 0;
      stub_prod <= prod_t'(int'(mult_mc) * int'(mult_mp));
    end else if (stub_run && stub_cnt < MULT_LATENCY_C) begin
      stub_cnt <= stub_cnt + 1;
    end
  end
  assign mult_ready = stub_run && (stub_cnt == MULT_LATENCY_C) && !stub_dead;
  assign mult_prod  = stub_prod;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  // Presents one request, waits for its grant, then counts edges to rsp_valid.
  task automatic issue(input int id, input data_t mc, input data_t mp, output int lat);
    bus.req_valid[id] = 1'b1;
    bus.req_mc[id]    = mc;
    bus.req_mp[id]    = mp;
    #1;
    for (int k = 0; k < 60; k++) begin
      if (bus.req_ready[id]) break;
      tick();
    end
    n_checks++;
    if (bus.req_ready[id] !== 1'b1) begin
      n_fail++; $display("FAIL issue_grant id=%0d: req_ready=%b required 1", id, bus.req_ready[id]);
    end
    tick();
    bus.req_valid[id] = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_mc = '0; bus.req_mp = '0; bus.rsp_ready = 1'b0;
    repeat (2) tick();
    n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d required IDLE", state_dbg); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id: got %h required 0", bus.rsp_id); end
    n_checks++; if (bus.rsp_prod !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_prod: got %h required 0", bus.rsp_prod); end
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b required 0", bus.rsp_err); end
    n_checks++; if (mult_start !== 1'b0) begin n_fail++; $display("FAIL reset_mult_start: got %b required 0", mult_start); end
    n_checks++; if (ptr_dbg !== 1'b0) begin n_fail++; $display("FAIL reset_ptr: got %h required 0", ptr_dbg); end
    n_checks++; if (mult_mc !== 16'h0 || mult_mp !== 16'h0) begin n_fail++; $display("FAIL reset_operands: got %h/%h required 0/0", mult_mc, mult_mp); end
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b required 00", bus.req_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int lat;
    issue(0, 16'sd7, -16'sd3, lat);
    n_checks++; if (lat !== 19) begin n_fail++; $display("FAIL single_latency: got %0d required 19", lat); end
    n_checks++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL single_id: got %h required 0", bus.rsp_id); end
    n_checks++; if (bus.rsp_prod !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL single_prod: got %h required FFFFFFEB", bus.rsp_prod); end
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b required 0", bus.rsp_err); end
    consume();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_after: busy=%b required 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [ID_W-1:0] exp_id [4];
    prod_t           exp_prod [4];
    int              k;
    exp_id   = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_prod = '{32'd30, 32'hFFFF_FFDC, 32'd30, 32'hFFFF_FFDC};
    rst_n = 1'b0;
    bus.req_mc[0] = 16'sd5;  bus.req_mp[0] = 16'sd6;
    bus.req_mc[1] = -16'sd4; bus.req_mp[1] = 16'sd9;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      k = 0;
      while (!bus.rsp_valid && k < 60) begin tick(); k++; end
      n_checks++; if (bus.rsp_id !== exp_id[r]) begin n_fail++; $display("FAIL rr_id[%0d]: got %h required %h", r, bus.rsp_id, exp_id[r]); end
      n_checks++; if (bus.rsp_prod !== exp_prod[r]) begin n_fail++; $display("FAIL rr_prod[%0d]: got %h required %h", r, bus.rsp_prod, exp_prod[r]); end
      tick();
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    tick();
  endtask

  task automatic test_boundary();
    int lat;
    issue(1, 16'sd32767, -16'sd32768, lat);
    n_checks++; if (bus.rsp_id !== 1'b1) begin n_fail++; $display("FAIL bound_max_id: got %h required 1", bus.rsp_id); end
    n_checks++; if (bus.rsp_prod !== 32'hC000_8000) begin n_fail++; $display("FAIL bound_max_prod: got %h required C0008000", bus.rsp_prod); end
    consume();
    issue(0, 16'sd0, -16'sd1, lat);
    n_checks++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL bound_zero_id: got %h required 0", bus.rsp_id); end
    n_checks++; if (bus.rsp_prod !== 32'h0) begin n_fail++; $display("FAIL bound_zero_prod: got %h required 0", bus.rsp_prod); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(0, 16'sd12, 16'sd12, lat);
    bus.req_mc[1] = -16'sd2; bus.req_mp[1] = -16'sd8; bus.req_valid[1] = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b required 1", c, bus.rsp_valid); end
      n_checks++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL bp_id[%0d]: got %h required 0", c, bus.rsp_id); end
      n_checks++; if (bus.rsp_prod !== 32'd144) begin n_fail++; $display("FAIL bp_prod[%0d]: got %h required 00000090", c, bus.rsp_prod); end
      n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL bp_err[%0d]: got %b required 0", c, bus.rsp_err); end
      n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %b required 00", c, bus.req_ready); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy[%0d]: got %b required 1", c, busy); end
      tick();
    end
    consume();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle_busy: got %b required 0", busy); end
    n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_pending_grant: got %b required 10", bus.req_ready); end
    tick();
    bus.req_valid[1] = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 60) begin tick(); lat++; end
    n_checks++; if (bus.rsp_id !== 1'b1) begin n_fail++; $display("FAIL bp_pending_id: got %h required 1", bus.rsp_id); end
    n_checks++; if (bus.rsp_prod !== 32'd16) begin n_fail++; $display("FAIL bp_pending_prod: got %h required 00000010", bus.rsp_prod); end
    consume();
  endtask

  task automatic test_timeout();
    int lat;
    stub_dead = 1'b1;
    issue(1, 16'sd5, 16'sd5, lat);
    n_checks++; if (lat !== 22) begin n_fail++; $display("FAIL timeout_latency: got %0d required 22", lat); end
    n_checks++; if (bus.rsp_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b required 1", bus.rsp_err); end
    n_checks++; if (bus.rsp_prod !== 32'h0) begin n_fail++; $display("FAIL timeout_prod: got %h required 0", bus.rsp_prod); end
    n_checks++; if (bus.rsp_id !== 1'b1) begin n_fail++; $display("FAIL timeout_id: got %h required 1", bus.rsp_id); end
    consume();
    stub_dead = 1'b0;
    issue(0, -16'sd7, -16'sd7, lat);
    n_checks++; if (lat !== 19) begin n_fail++; $display("FAIL recover_latency: got %0d required 19", lat); end
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL recover_err: got %b required 0", bus.rsp_err); end
    n_checks++; if (bus.rsp_prod !== 32'd49) begin n_fail++; $display("FAIL recover_prod: got %h required 00000031", bus.rsp_prod); end
    consume();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    bus.req_mc[0] = 16'sd2; bus.req_mp[0] = 16'sd2; bus.req_valid[0] = 1'b1;
    #1;
    for (int k = 0; k < 60; k++) begin
      if (bus.req_ready[0]) break;
      tick();
    end
    tick();
    bus.req_valid[0] = 1'b0;
    repeat (5) tick();
    n_checks++; if (state_dbg !== WAIT) begin n_fail++; $display("FAIL midrst_in_wait: got %0d required WAIT", state_dbg); end
    n_checks++; if (ptr_dbg !== 1'b1) begin n_fail++; $display("FAIL midrst_ptr_before: got %h required 1", ptr_dbg); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b required 0", busy); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp_valid: got %b required 0", bus.rsp_valid); end
    n_checks++; if (ptr_dbg !== 1'b0) begin n_fail++; $display("FAIL midrst_ptr: got %h required 0", ptr_dbg); end
    issue(0, 16'sd3, 16'sd3, lat);
    n_checks++; if (lat !== 19) begin n_fail++; $display("FAIL midrst_next_latency: got %0d required 19", lat); end
    n_checks++; if (bus.rsp_prod !== 32'd9) begin n_fail++; $display("FAIL midrst_next_prod: got %h required 00000009", bus.rsp_prod); end
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL midrst_next_err: got %b required 0", bus.rsp_err); end
    consume();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_boundary();
    test_backpressure();
    test_timeout();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within 100000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
